hazard_stall_ctrl: RTL

- Control-side counterpart of the D/E/M/W pipeline registers in the 5-stage MIPS core. It consumes the instruction words held in those registers and drives their stall/clear inputs.
- It detects RAW hazards the forwarding network cannot cover, plus mult/div unit occupancy.
- It asserts stallD to freeze PC and the D register, and bubbleE to clear the E register.
- It contains a multi-cycle mult/div busy FSM, so stall timing depends on history and not only on the current instruction words.

---
 rtl/hazard_stall_ctrl_pkg.sv | 54 +++++
 rtl/hazard_stall_ctrl_if.sv | 23 ++
 rtl/hazard_stall_ctrl_instr_class_decode.sv | 101 ++++++++++
 rtl/hazard_stall_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared MIPS decode constants, hazard timing widths and mult/div state encodings
// for the hazard/stall controller.
package mips_defs;

  localparam int unsigned REG_W = 5;
  localparam int unsigned T_W   = 2;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2
  } md_state_t;

  typedef enum logic [1:0] {
    MDC_NONE = 2'd0,
    MDC_MULT = 2'd1,
    MDC_DIV  = 2'd2,
    MDC_MOVE = 2'd3
  } md_class_t;

  // One source-vs-producer RAW check: producer result not forwardable in time.
  function automatic logic raw_hit(input logic [REG_W-1:0] src,
                                   input logic             src_used,
                                   input logic [T_W-1:0]   tuse,
                                   input logic             wr_en,
                                   input logic [REG_W-1:0] dst,
                                   input logic [T_W-1:0]   tnew);
    return src_used && wr_en && (dst != '0) && (dst == src) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-register instruction/enable bundle and the stall/bubble controls
// returned to those registers.
interface hazard_stall_ctrl_if;
  logic [31:0] InstrD;
  logic [31:0] InstrE;
  logic [31:0] InstrM;
  logic        regWriteE;
  logic        regWriteM;
  logic        stallD;
  logic        bubbleE;
  logic        mdBusy;
  logic [1:0]  mdState;

  modport master (
    output InstrD, InstrE, InstrM, regWriteE, regWriteM,
    input  stallD, bubbleE, mdBusy, mdState
  );

  modport slave (
    input  InstrD, InstrE, InstrM, regWriteE, regWriteM,
    output stallD, bubbleE, mdBusy, mdState
  );
endinterface

// File: rtl/hazard_stall_ctrl_instr_class_decode.sv
// Classifies one instruction word: source/dest registers, Tnew (as seen in E),
// per-source Tuse and mult/div class.
module instr_class_decode
  import mips_defs::*;
(
  input  logic [31:0]      instr,
  output logic [REG_W-1:0] rs,
  output logic [REG_W-1:0] rt,
  output logic [REG_W-1:0] dest,
  output logic [T_W-1:0]   tnew,
  output logic [T_W-1:0]   tuse_rs,
  output logic [T_W-1:0]   tuse_rt,
  output logic             use_rs,
  output logic             use_rt,
  output md_class_t        md_class
);

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [REG_W-1:0] rd;
  logic             unused_shamt;

  assign op           = instr[31:26];
  assign funct        = instr[5:0];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    dest     = '0;
    tnew     = '0;
    tuse_rs  = '0;
    tuse_rt  = '0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    md_class = MDC_NONE;
    case (op)
      OP_SPECIAL: begin
        dest = rd;
        tnew = T_W'(1);
        case (funct)
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            md_class = (funct == FN_MULT || funct == FN_MULTU) ? MDC_MULT : MDC_DIV;
            use_rs   = 1'b1;
            use_rt   = 1'b1;
            tuse_rs  = T_W'(1);
            tuse_rt  = T_W'(1);
          end
          FN_MTHI, FN_MTLO: begin
            md_class = MDC_MOVE;
            use_rs   = 1'b1;
            tuse_rs  = T_W'(1);
          end
          FN_MFHI, FN_MFLO: md_class = MDC_MOVE;
          FN_JR:            use_rs = 1'b1;
          FN_JALR: begin
            // link value is PC+8, available immediately like jal
            use_rs = 1'b1;
            tnew   = '0;
          end
          default: begin
            use_rs  = 1'b1;
            use_rt  = 1'b1;
            tuse_rs = T_W'(1);
            tuse_rt = T_W'(1);
          end
        endcase
      end
      OP_LW: begin
        dest    = rt;
        tnew    = T_W'(2);
        use_rs  = 1'b1;
        tuse_rs = T_W'(1);
      end
      OP_SW: begin
        use_rs  = 1'b1;
        use_rt  = 1'b1;
        tuse_rs = T_W'(1);
        tuse_rt = T_W'(2);
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: begin
        dest    = rt;
        tnew    = T_W'(1);
        use_rs  = 1'b1;
        tuse_rs = T_W'(1);
      end
      OP_LUI: begin
        dest = rt;
        tnew = T_W'(1);
      end
      OP_BEQ, OP_BNE: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_JAL: dest = REG_W'(31);
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble generation for the D/E pipeline registers: RAW hazards the
// forwarding network cannot cover plus HI/LO unit occupancy.
module hazard_stall_ctrl
  import mips_defs::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  hazard_stall_ctrl_if.slave bus
);

  logic [REG_W-1:0] rs_d, rt_d, dest_d, rs_e, rt_e, dest_e, rs_m, rt_m, dest_m;
  logic [T_W-1:0]   tnew_d, tnew_e, tnew_m_raw, tnew_m;
  logic [T_W-1:0]   tuse_rs_d, tuse_rt_d, tuse_rs_e, tuse_rt_e, tuse_rs_m, tuse_rt_m;
  logic             use_rs_d, use_rt_d, use_rs_e, use_rt_e, use_rs_m, use_rt_m;
  md_class_t        md_d, md_e, md_m;

  instr_class_decode u_dec_d (
    .instr(bus.InstrD), .rs(rs_d), .rt(rt_d), .dest(dest_d), .tnew(tnew_d),
    .tuse_rs(tuse_rs_d), .tuse_rt(tuse_rt_d), .use_rs(use_rs_d), .use_rt(use_rt_d),
    .md_class(md_d)
  );

  instr_class_decode u_dec_e (
    .instr(bus.InstrE), .rs(rs_e), .rt(rt_e), .dest(dest_e), .tnew(tnew_e),
    .tuse_rs(tuse_rs_e), .tuse_rt(tuse_rt_e), .use_rs(use_rs_e), .use_rt(use_rt_e),
    .md_class(md_e)
  );

  instr_class_decode u_dec_m (
    .instr(bus.InstrM), .rs(rs_m), .rt(rt_m), .dest(dest_m), .tnew(tnew_m_raw),
    .tuse_rs(tuse_rs_m), .tuse_rt(tuse_rt_m), .use_rs(use_rs_m), .use_rt(use_rt_m),
    .md_class(md_m)
  );

  logic unused_dec;
  assign unused_dec = ^{dest_d, tnew_d, rs_e, rt_e, tuse_rs_e, tuse_rt_e, use_rs_e,
                        use_rt_e, rs_m, rt_m, tuse_rs_m, tuse_rt_m, use_rs_m,
                        use_rt_m, md_m};

  // Decoder reports Tnew as seen in E; one stage later it is one cycle closer.
  assign tnew_m = (tnew_m_raw == '0) ? '0 : tnew_m_raw - T_W'(1);

  logic data_stall;
  assign data_stall =
      raw_hit(rs_d, use_rs_d, tuse_rs_d, bus.regWriteE, dest_e, tnew_e) |
      raw_hit(rs_d, use_rs_d, tuse_rs_d, bus.regWriteM, dest_m, tnew_m) |
      raw_hit(rt_d, use_rt_d, tuse_rt_d, bus.regWriteE, dest_e, tnew_e) |
      raw_hit(rt_d, use_rt_d, tuse_rt_d, bus.regWriteM, dest_m, tnew_m);

  md_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Busy window includes the entry cycle, so leave once the count has run down to 1.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      MD_IDLE: begin
        if (md_e == MDC_MULT) begin
          state_n = MD_MULT;
          cnt_n   = CNT_W'(MULT_CYCLES - 1);
        end else if (md_e == MDC_DIV) begin
          state_n = MD_DIV;
          cnt_n   = CNT_W'(DIV_CYCLES - 1);
        end
      end
      MD_MULT, MD_DIV: begin
        if (cnt <= CNT_W'(1)) begin
          state_n = MD_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = MD_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  logic md_busy, md_stall, stall;
  assign md_busy  = (state != MD_IDLE) || (md_e == MDC_MULT) || (md_e == MDC_DIV);
  assign md_stall = (md_d != MDC_NONE) && md_busy;
  assign stall    = data_stall | md_stall;

  assign bus.stallD  = stall;
  assign bus.bubbleE = stall;
  assign bus.mdBusy  = md_busy;
  assign bus.mdState = state;

endmodule
